// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered D_N-bit adder among N_REQ requesters.
// Optional macro ADDER_ARBITER_SUB_EN adds a per-requester w_sub port selecting a - b.
module adder_arbiter #(
  parameter int D_N   = 32,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic [N_REQ-1:0]       w_req,
  input  logic [N_REQ*D_N-1:0]   w_a,
  input  logic [N_REQ*D_N-1:0]   w_b,
`ifdef ADDER_ARBITER_SUB_EN
  input  logic [N_REQ-1:0]       w_sub,
`endif
  output logic [N_REQ-1:0]       w_gnt,
  output logic                   w_res_valid,
  output logic [ID_W-1:0]        w_res_id,
  output logic [D_N-1:0]         w_res_sum,
  output logic                   w_res_cout,
  input  logic                   w_res_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_REQ-1:0] GNT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ID_W-1:0]   last_r;
  logic [ID_W-1:0]   id_r;
  logic [ID_W-1:0]   res_id_r;
  logic [ID_W-1:0]   win_s;
  logic              found_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [D_N-1:0]    a_r;
  logic [D_N-1:0]    b_r;
  logic [D_N-1:0]    sum_r;
  logic              cout_r;
  logic              valid_r;
  logic [D_N:0]      full_s;
`ifdef ADDER_ARBITER_SUB_EN
  logic              sub_r;
`endif

  // Round-robin winner search starting just after the last served requester.
  always_comb begin
    found_s = 1'b0;
    win_s   = {ID_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx     = (int'(last_r) + k) % N_REQ;
      win_s   = w_req[idx] ? ID_W'(idx) : win_s;
      found_s = found_s | w_req[idx];
    end
  end

  // Next-state decode and grant; the grant is suppressed while reset is held.
  always_comb begin
    state_nxt_s = state_r;
    gnt_s       = {N_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = CALC;
          gnt_s       = GNT_LSB << win_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: state_nxt_s = DONE;
      DONE: begin
        if (w_res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    if (w_rst_n) begin
      w_gnt = gnt_s;
    end else begin
      w_gnt = {N_REQ{1'b0}};
    end
  end

  // Shared adder; subtraction is a + ~b + 1 so carry-out doubles as "no borrow".
  always_comb begin
`ifdef ADDER_ARBITER_SUB_EN
    if (sub_r) begin
      full_s = {1'b0, a_r} + {1'b0, ~b_r} + (D_N+1)'(1);
    end else begin
      full_s = {1'b0, a_r} + {1'b0, b_r};
    end
`else
    full_s = {1'b0, a_r} + {1'b0, b_r};
`endif
  end

  // State register.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, result registers and round-robin pointer.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      last_r   <= ID_W'(N_REQ - 1);
      id_r     <= {ID_W{1'b0}};
      res_id_r <= {ID_W{1'b0}};
      a_r      <= {D_N{1'b0}};
      b_r      <= {D_N{1'b0}};
      sum_r    <= {D_N{1'b0}};
      cout_r   <= 1'b0;
      valid_r  <= 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
      sub_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            a_r    <= w_a[win_s*D_N +: D_N];
            b_r    <= w_b[win_s*D_N +: D_N];
            id_r   <= win_s;
            last_r <= win_s;
`ifdef ADDER_ARBITER_SUB_EN
            sub_r  <= w_sub[win_s];
`endif
          end
        end
        CALC: begin
          {cout_r, sum_r} <= full_s;
          res_id_r        <= id_r;
          valid_r         <= 1'b1;
        end
        DONE: begin
          if (w_res_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign w_res_valid = valid_r;
  assign w_res_id    = res_id_r;
  assign w_res_sum   = sum_r;
  assign w_res_cout  = cout_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scoreboard bench for adder_arbiter; define ADDER_ARBITER_SUB_EN to also exercise subtraction.
module tb_adder_arbiter;
  localparam int D_N   = 32;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            cout;
    logic [D_N-1:0]  sum;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*D_N-1:0] a;
  logic [N_REQ*D_N-1:0] b;
`ifdef ADDER_ARBITER_SUB_EN
  logic [N_REQ-1:0]     sub;
`endif
  logic [N_REQ-1:0]     gnt;
  logic                 res_valid;
  logic [ID_W-1:0]      res_id;
  logic [D_N-1:0]       res_sum;
  logic                 res_cout;
  logic                 res_ready;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mlast    = N_REQ - 1;

  always #5 clk = ~clk;

  adder_arbiter #(.D_N(D_N), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .w_clk      (clk),
    .w_rst_n    (rst_n),
    .w_req      (req),
    .w_a        (a),
    .w_b        (b),
`ifdef ADDER_ARBITER_SUB_EN
    .w_sub      (sub),
`endif
    .w_gnt      (gnt),
    .w_res_valid(res_valid),
    .w_res_id   (res_id),
    .w_res_sum  (res_sum),
    .w_res_cout (res_cout),
    .w_res_ready(res_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N_REQ-1:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (mlast + k) % N_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic ent_t model_res(input int i);
    logic [D_N-1:0] av;
    logic [D_N-1:0] bv;
    logic [D_N:0]   f;
    ent_t           e;
    av = a[i*D_N +: D_N];
    bv = b[i*D_N +: D_N];
    f  = D_N'(0);
    f  = av + f + bv;
`ifdef ADDER_ARBITER_SUB_EN
    if (sub[i]) begin
      f[D_N-1:0] = av - bv;
      f[D_N]     = (av >= bv);
    end
`endif
    e.id   = ID_W'(i);
    e.cout = f[D_N];
    e.sum  = f[D_N-1:0];
    return e;
  endfunction

  task automatic set_op(input int i, input logic [D_N-1:0] av, input logic [D_N-1:0] bv);
    a[i*D_N +: D_N] = av;
    b[i*D_N +: D_N] = bv;
  endtask

  // One full transaction from IDLE; hold > 0 keeps ready low for that many DONE cycles.
  task automatic op(input int hold, input bit use_exp, input logic [D_N-1:0] xs, input logic xc);
    int   w;
    int   n;
    ent_t e;
    #1;
    w = model_winner(req);
    check("gnt", gnt, (w < 0) ? 0 : (1 << w));
    if (w < 0) return;
    e = model_res(w);
    if (use_exp) begin
      e.sum  = xs;
      e.cout = xc;
    end
    sb.push_back(e);
    mlast     = w;
    res_ready = (hold == 0);
    @(negedge clk);
    check("calc_gnt", gnt, 0);
    check("calc_valid", res_valid, 0);
    for (int k = 0; k < 4 && res_valid !== 1'b1; k++) @(negedge clk);
    e = sb.pop_front();
    n = (hold > 0) ? hold : 1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      check("res_valid", res_valid, 1);
      check("res_id", res_id, e.id);
      check("res_sum", res_sum, e.sum);
      check("res_cout", res_cout, e.cout);
      check("done_gnt", gnt, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("idle_valid", res_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n     = 1'b0;
    req       = 4'b1111;
    res_ready = 1'b1;
    a         = '0;
    b         = '0;
`ifdef ADDER_ARBITER_SUB_EN
    sub       = 4'b0000;
`endif
    for (int i = 0; i < N_REQ; i++) set_op(i, $urandom, $urandom);
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_sum", res_sum, 0);
    check("rst_cout", res_cout, 0);

    // Release reset with all requesting: 0001, 0010, 0100, 1000, 0001.
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N_REQ; i++) set_op(i, $urandom, $urandom);
      op(0, 1'b0, '0, 1'b0);
    end

    // No request: stays idle.
    req = 4'b0000;
    #1;
    check("noreq_gnt", gnt, 0);
    @(negedge clk);
    check("noreq_valid", res_valid, 0);

    req = 4'b0100;
    set_op(2, 32'h0000_0005, 32'h0000_0007);
    op(0, 1'b1, 32'd12, 1'b0);

    req = 4'b0010;
    set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
    op(0, 1'b1, 32'h0000_0000, 1'b1);

    // Back-pressure, then round-robin continues from the served index.
    req = 4'b1111;
    op(5, 1'b0, '0, 1'b0);
    op(0, 1'b0, '0, 1'b0);

    // Reset during CALC discards the operation.
    #1;
    w = model_winner(req);
    check("pre_rst_gnt", gnt, 1 << w);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", res_valid, 0);
    check("midrst_id", res_id, 0);
    check("midrst_sum", res_sum, 0);
    check("midrst_cout", res_cout, 0);
    check("midrst_gnt", gnt, 0);
    rst_n = 1'b1;
    mlast = N_REQ - 1;
    op(0, 1'b0, '0, 1'b0);

`ifdef ADDER_ARBITER_SUB_EN
    req = 4'b0001;
    sub = 4'b0001;
    set_op(0, 32'd10, 32'd3);
    op(0, 1'b1, 32'd7, 1'b1);
    set_op(0, 32'd3, 32'd10);
    op(0, 1'b1, 32'hFFFF_FFF9, 1'b0);
    sub = 4'b0000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
